// File: rtl/bus_arbiter_4_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_arbiter_4_pkg
// Purpose : Shared types, constants and the round-robin helper function for
//           the 4-way bus arbiter (and future arbiters of the same family).
// Ports   : n/a (package)
// Rev     : 1.0  initial release
// ============================================================================
package bus_arbiter_4_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot of the first set req bit scanning ptr+1, ptr+2, ptr+3, ptr.
  // The scan runs from lowest to highest priority so the highest-priority
  // hit is the one left standing.
  function automatic logic [NUM_REQ-1:0] rr_onehot(input logic [NUM_REQ-1:0] req,
                                                   input logic [1:0]         ptr);
    logic [NUM_REQ-1:0] oh;
    logic [1:0]         idx;
    oh = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) oh = NUM_REQ'(1) << idx;
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_4_if.sv
`default_nettype none
// ============================================================================
// Module  : bus_arbiter_4_if
// Purpose : Bundle of requester-side and downstream-side signals of the
//           4-way bus arbiter.
// Ports   : master = requesters + downstream (drive req/last/data/out_ready)
//           slave  = arbiter (drives out_valid/out_data/out_sel/gnt/
//                    beat_ack/busy)
// Rev     : 1.0  initial release
// ============================================================================
interface bus_arbiter_4_if #(
  parameter int WIDTH = 16
);
  import bus_arbiter_4_pkg::*;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            last;
  logic [NUM_REQ-1:0][WIDTH-1:0] data;
  logic                          out_ready;
  logic                          out_valid;
  logic [WIDTH-1:0]              out_data;
  logic [1:0]                    out_sel;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            beat_ack;
  logic                          busy;

  modport master (
    output req, last, data, out_ready,
    input  out_valid, out_data, out_sel, gnt, beat_ack, busy
  );

  modport slave (
    input  req, last, data, out_ready,
    output out_valid, out_data, out_sel, gnt, beat_ack, busy
  );

endinterface
`default_nettype wire

// File: rtl/bus_arbiter_4_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick4
// Purpose : Combinational round-robin picker; ptr_i is the previous owner and
//           gets lowest priority.
// Ports   : req_i (4) requests, ptr_i (2) last owner,
//           idx_o (2) picked index, any_o (1) at least one request
// Rev     : 1.0  initial release
// ============================================================================
module rr_pick4
  import bus_arbiter_4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic [1:0]         idx_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] oh;

  always_comb begin
    oh    = rr_onehot(req_i, ptr_i);
    idx_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx_o = 2'(i);
    end
    any_o = |req_i;
  end

endmodule
`default_nettype wire

// File: rtl/mux_4.sv
`default_nettype none
// ============================================================================
// Module  : mux_4
// Purpose : 4:1 data multiplexer.
// Ports   : sel_i (2) select, d0_i..d3_i (WIDTH) data in, y_o (WIDTH) out
// Rev     : 1.0  initial release
// ============================================================================
module mux_4 #(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    case (sel_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      default: y_o = d3_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module  : bus_arbiter_4
// Purpose : Round-robin arbiter/sequencer sharing one 16-bit downstream port
//           among 4 requesters, holding each grant for a burst.
// Ports   : clk (1) clock, rst (1) async active-high reset,
//           bus (bus_arbiter_4_if.slave): req/last/data/out_ready in,
//           out_valid/out_data/out_sel/gnt/beat_ack/busy out
// Rev     : 1.0  initial release
// ============================================================================
module bus_arbiter_4
  import bus_arbiter_4_pkg::*;
#(
  parameter int MAX_BEATS = 8,
  parameter int WIDTH     = 16
) (
  input  logic            clk,
  input  logic            rst,
  bus_arbiter_4_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [1:0]         sel_q;   // current owner in GRANT, last owner in IDLE
  logic [1:0]         ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               valid;
  logic               xfer;
  logic [NUM_REQ-1:0] ack;
  logic               rel;
  logic [1:0]         pick_ptr;
  logic [1:0]         pick_idx;
  logic               pick_any;
  logic [WIDTH-1:0]   mux_data;

  always_comb begin
    valid = (state_q == GRANT) & bus.req[sel_q];
    xfer  = valid & bus.out_ready;
    ack   = '0;
    if (xfer) ack[sel_q] = 1'b1;
    // Withdrawal releases without a beat; last/limit only count on a beat.
    rel = (state_q == GRANT) &
          (~bus.req[sel_q] |
           (xfer & (bus.last[sel_q] | (cnt_q == CNT_W'(MAX_BEATS - 1)))));
    // On release the current owner becomes the new lowest-priority slot in
    // the same cycle, ahead of ptr_q catching up.
    pick_ptr = (state_q == GRANT) ? sel_q : ptr_q;
  end

  rr_pick4 u_pick (
    .req_i (bus.req),
    .ptr_i (pick_ptr),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  mux_4 #(.WIDTH(WIDTH)) u_mux (
    .sel_i (sel_q),
    .d0_i  (bus.data[0]),
    .d1_i  (bus.data[1]),
    .d2_i  (bus.data[2]),
    .d3_i  (bus.data[3]),
    .y_o   (mux_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q <= GRANT;
            gnt_q   <= NUM_REQ'(1) << pick_idx;
            sel_q   <= pick_idx;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr_q <= sel_q;
            cnt_q <= '0;
            if (pick_any) begin
              gnt_q <= NUM_REQ'(1) << pick_idx;
              sel_q <= pick_idx;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
            end
          end else if (xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.out_valid = valid;
  assign bus.out_data  = mux_data;
  assign bus.out_sel   = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.beat_ack  = ack;
  assign bus.busy      = (state_q == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_arbiter_4
// Purpose : Self-checking bench for bus_arbiter_4 (MAX_BEATS = 8).
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_bus_arbiter_4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] ack;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  exp_t  sb[$];
  string tq[$];

  logic [3:0][15:0] DATA;

  bus_arbiter_4_if #(.WIDTH(16)) bus ();

  bus_arbiter_4 #(.MAX_BEATS(8), .WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue what the DUT
  // must show for that cycle.
  task automatic drv(input string tag, input logic r, input logic [3:0] rq,
                     input logic [3:0] lst, input logic rdy,
                     input logic [3:0] eg, input logic [1:0] es, input logic ev,
                     input logic [3:0] ea, input logic eb);
    exp_t e;
    @(negedge clk);
    rst           = r;
    bus.req       = rq;
    bus.last      = lst;
    bus.out_ready = rdy;
    e.gnt   = eg;
    e.sel   = es;
    e.valid = ev;
    e.ack   = ea;
    e.busy  = eb;
    sb.push_back(e);
    tq.push_back(tag);
  endtask

  // Monitor: compare queued expectations shortly after each falling edge.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        t = tq.pop_front();
        chk({t, ".gnt"},   32'(bus.gnt),       32'(e.gnt));
        chk({t, ".sel"},   32'(bus.out_sel),   32'(e.sel));
        chk({t, ".valid"}, 32'(bus.out_valid), 32'(e.valid));
        chk({t, ".ack"},   32'(bus.beat_ack),  32'(e.ack));
        chk({t, ".busy"},  32'(bus.busy),      32'(e.busy));
        chk({t, ".data"},  32'(bus.out_data),  32'(DATA[e.sel]));
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    DATA     = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
    rst           = 1'b1;
    bus.req       = '0;
    bus.last      = '0;
    bus.out_ready = 1'b0;
    bus.data      = DATA;

    // Reset state
    repeat (2) drv("rst0", 1, 4'b0000, 4'b0000, 0, 4'h0, 2'd0, 0, 4'h0, 0);

    // Contention: all request, every beat is last -> 0,1,2,3,0
    drv("c_idle", 0, 4'b1111, 4'b1111, 1, 4'h0, 2'd0, 0, 4'h0, 0);
    for (int i = 0; i < 5; i++)
      drv("c_own", 0, 4'b1111, 4'b1111, 1, 4'(1 << (i % 4)), 2'(i % 4), 1, 4'(1 << (i % 4)), 1);
    drv("c_wd",    0, 4'b0000, 4'b0000, 1, 4'b0010, 2'd1, 0, 4'h0, 1);
    drv("c_idle2", 0, 4'b0000, 4'b0000, 1, 4'h0,    2'd1, 0, 4'h0, 0);

    // Burst limit: req0 never last -> 8 beats then hand over to 1
    drv("b_idle", 0, 4'b0011, 4'b0000, 1, 4'h0, 2'd1, 0, 4'h0, 0);
    repeat (8) drv("b_beat", 0, 4'b0011, 4'b0000, 1, 4'b0001, 2'd0, 1, 4'b0001, 1);
    drv("b_next",  0, 4'b0011, 4'b0000, 1, 4'b0010, 2'd1, 1, 4'b0010, 1);
    drv("b_wd",    0, 4'b0000, 4'b0000, 1, 4'b0010, 2'd1, 0, 4'h0,    1);
    drv("b_idle2", 0, 4'b0000, 4'b0000, 1, 4'h0,    2'd1, 0, 4'h0,    0);

    // Stall: owner 2 held through 5 not-ready cycles (one with a stray last);
    // the counter must resume so release lands after 8 accepted beats.
    drv("s_idle", 0, 4'b0110, 4'b0000, 1, 4'h0,    2'd1, 0, 4'h0,    0);
    drv("s_beat", 0, 4'b0110, 4'b0000, 1, 4'b0100, 2'd2, 1, 4'b0100, 1);
    for (int i = 0; i < 5; i++)
      drv("s_stall", 0, 4'b0110, (i == 1) ? 4'b0100 : 4'b0000, 0, 4'b0100, 2'd2, 1, 4'h0, 1);
    repeat (7) drv("s_beat", 0, 4'b0110, 4'b0000, 1, 4'b0100, 2'd2, 1, 4'b0100, 1);
    drv("s_next",  0, 4'b0000, 4'b0000, 1, 4'b0010, 2'd1, 0, 4'h0, 1);
    drv("s_idle2", 0, 4'b0000, 4'b0000, 1, 4'h0,    2'd1, 0, 4'h0, 0);

    // Withdrawal: owner 1 drops after 2 beats, requester 3 takes over
    drv("w_idle", 0, 4'b0010, 4'b0000, 1, 4'h0, 2'd1, 0, 4'h0, 0);
    repeat (2) drv("w_beat", 0, 4'b0010, 4'b0000, 1, 4'b0010, 2'd1, 1, 4'b0010, 1);
    drv("w_drop", 0, 4'b1000, 4'b0000, 1, 4'b0010, 2'd1, 0, 4'h0,    1);
    drv("w_own3", 0, 4'b1000, 4'b1000, 1, 4'b1000, 2'd3, 1, 4'b1000, 1);
    drv("w_rel",  0, 4'b0000, 4'b0000, 1, 4'b1000, 2'd3, 0, 4'h0,    1);
    // Idle with select held on last owner
    repeat (2) drv("w_hold", 0, 4'b0000, 4'b0000, 1, 4'h0, 2'd3, 0, 4'h0, 0);

    // Reset mid-burst: immediate drop, first grant afterwards goes to 0
    drv("r_idle", 0, 4'b0100, 4'b0000, 1, 4'h0,    2'd3, 0, 4'h0,    0);
    drv("r_beat", 0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 4'b0100, 1);
    repeat (2) drv("r_rst", 1, 4'b1111, 4'b0000, 1, 4'h0, 2'd0, 0, 4'h0, 0);
    drv("r_idle2", 0, 4'b1111, 4'b0000, 1, 4'h0,    2'd0, 0, 4'h0,    0);
    drv("r_first", 0, 4'b1111, 4'b0000, 1, 4'b0001, 2'd0, 1, 4'b0001, 1);
    drv("r_wd",    0, 4'b0000, 4'b0000, 1, 4'b0001, 2'd0, 0, 4'h0,    1);
    drv("r_end",   0, 4'b0000, 4'b0000, 1, 4'h0,    2'd0, 0, 4'h0,    0);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
